// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS main controller: opcodes, ALUOp codes,
// mux-select codes and the FSM state encoding.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    OPC_LOAD,
    OPC_STORE,
    OPC_RTYPE,
    OPC_BEQ,
    OPC_ADDI,
    OPC_JUMP,
    OPC_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/multicycle_control.sv
// Moore FSM main controller for the multicycle MIPS datapath with a variable-latency
// memory handshake, optional ADDI/J decode and an illegal-opcode trap.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned OPW         = 6,
  parameter bit          ENABLE_ADDI = 1'b1,
  parameter bit          ENABLE_J    = 1'b1,
  parameter bit          USE_MEM_RDY = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] Opcode,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           IorD,
  output logic           IRWrite,
  output logic           MemWrite,
  output logic           PCWrite,
  output logic           Branch,
  output logic [1:0]     PCSrc,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           illegal_op,
  output logic [3:0]     state_o
);

  state_t    state_q, state_d;
  logic      mem_ok;
  op_class_t op_class;

  function automatic op_class_t classify(input logic [OPW-1:0] op);
    op_class_t c;
    c = OPC_ILLEGAL;
    if (op == OPW'(OP_LW))                    c = OPC_LOAD;
    else if (op == OPW'(OP_SW))               c = OPC_STORE;
    else if (op == OPW'(OP_RTYPE))            c = OPC_RTYPE;
    else if (op == OPW'(OP_BEQ))              c = OPC_BEQ;
    else if (ENABLE_ADDI && op == OPW'(OP_ADDI)) c = OPC_ADDI;
    else if (ENABLE_J && op == OPW'(OP_J))    c = OPC_JUMP;
    return c;
  endfunction

  assign mem_ok   = USE_MEM_RDY ? mem_ready : 1'b1;
  assign op_class = classify(Opcode);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (op_class)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_RTYPE:           state_d = S_EXEC;
          OPC_BEQ:             state_d = S_BRANCH;
          OPC_ADDI:            state_d = S_ADDIEX;
          OPC_JUMP:            state_d = S_JUMP;
          default:             state_d = S_TRAP;
        endcase
      end
      // Opcode is re-sampled here; anything other than LW/SW by now is treated as illegal.
      S_MEMADR: begin
        case (op_class)
          OPC_LOAD:  state_d = S_MEMRD;
          OPC_STORE: state_d = S_MEMWR;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMRD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ok) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_TRAP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = PCSRC_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    ALUOp      = ALUOP_ADD;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    state_o    = reset ? '0 : state_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ok;
          PCWrite = mem_ok;
        end
        S_DECODE: ALUSrcB = SRCB_IMM_SH2;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = mem_ok;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_R;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_SUB;
          PCSrc   = PCSRC_ALUOUT;
          Branch  = 1'b1;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = PCSRC_JUMP;
        end
        S_TRAP:   illegal_op = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a default instance and one with J decode disabled.
module tb_multicycle_control;

  logic       clk = 1'b1;
  logic       reset;
  logic [5:0] Opcode;
  logic       mem_ready;

  logic       mem_req0, IorD0, IRWrite0, MemWrite0, PCWrite0, Branch0, ALUSrcA0;
  logic       RegDst0, MemtoReg0, RegWrite0, illegal_op0;
  logic [1:0] PCSrc0, ALUSrcB0, ALUOp0;
  logic [3:0] state0;
  logic       mem_req1, IorD1, IRWrite1, MemWrite1, PCWrite1, Branch1, ALUSrcA1;
  logic       RegDst1, MemtoReg1, RegWrite1, illegal_op1;
  logic [1:0] PCSrc1, ALUSrcB1, ALUOp1;
  logic [3:0] state1;

  always #5 clk = ~clk;

  multicycle_control #(.OPW(6), .ENABLE_ADDI(1'b1), .ENABLE_J(1'b1), .USE_MEM_RDY(1'b1)) dut0 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .mem_req(mem_req0), .IorD(IorD0), .IRWrite(IRWrite0), .MemWrite(MemWrite0),
    .PCWrite(PCWrite0), .Branch(Branch0), .PCSrc(PCSrc0), .ALUSrcA(ALUSrcA0),
    .ALUSrcB(ALUSrcB0), .ALUOp(ALUOp0), .RegDst(RegDst0), .MemtoReg(MemtoReg0),
    .RegWrite(RegWrite0), .illegal_op(illegal_op0), .state_o(state0)
  );

  multicycle_control #(.OPW(6), .ENABLE_ADDI(1'b1), .ENABLE_J(1'b0), .USE_MEM_RDY(1'b1)) dut1 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .mem_req(mem_req1), .IorD(IorD1), .IRWrite(IRWrite1), .MemWrite(MemWrite1),
    .PCWrite(PCWrite1), .Branch(Branch1), .PCSrc(PCSrc1), .ALUSrcA(ALUSrcA1),
    .ALUSrcB(ALUSrcB1), .ALUOp(ALUOp1), .RegDst(RegDst1), .MemtoReg(MemtoReg1),
    .RegWrite(RegWrite1), .illegal_op(illegal_op1), .state_o(state1)
  );

  // {state, mem_req, IorD, IRWrite, MemWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
  //  ALUOp, RegDst, MemtoReg, RegWrite, illegal_op}
  logic [20:0] act0, act1;
  assign act0 = {state0, mem_req0, IorD0, IRWrite0, MemWrite0, PCWrite0, Branch0, PCSrc0,
                 ALUSrcA0, ALUSrcB0, ALUOp0, RegDst0, MemtoReg0, RegWrite0, illegal_op0};
  assign act1 = {state1, mem_req1, IorD1, IRWrite1, MemWrite1, PCWrite1, Branch1, PCSrc1,
                 ALUSrcA1, ALUSrcB1, ALUOp1, RegDst1, MemtoReg1, RegWrite1, illegal_op1};

  localparam logic [20:0] E_RST   = 21'b0000_0_0_0_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [20:0] E_FET_R = 21'b0000_1_0_1_0_1_0_00_0_01_00_0_0_0_0;
  localparam logic [20:0] E_FET_W = 21'b0000_1_0_0_0_0_0_00_0_01_00_0_0_0_0;
  localparam logic [20:0] E_DEC   = 21'b0001_0_0_0_0_0_0_00_0_11_00_0_0_0_0;
  localparam logic [20:0] E_MADR  = 21'b0010_0_0_0_0_0_0_00_1_10_00_0_0_0_0;
  localparam logic [20:0] E_MRD   = 21'b0011_1_1_0_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [20:0] E_MWB   = 21'b0100_0_0_0_0_0_0_00_0_00_00_0_1_1_0;
  localparam logic [20:0] E_MWR_R = 21'b0101_1_1_0_1_0_0_00_0_00_00_0_0_0_0;
  localparam logic [20:0] E_MWR_W = 21'b0101_1_1_0_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [20:0] E_EXEC  = 21'b0110_0_0_0_0_0_0_00_1_00_10_0_0_0_0;
  localparam logic [20:0] E_AWB   = 21'b0111_0_0_0_0_0_0_00_0_00_00_1_0_1_0;
  localparam logic [20:0] E_BR    = 21'b1000_0_0_0_0_0_1_01_1_00_01_0_0_0_0;
  localparam logic [20:0] E_AIEX  = 21'b1001_0_0_0_0_0_0_00_1_10_00_0_0_0_0;
  localparam logic [20:0] E_AIWB  = 21'b1010_0_0_0_0_0_0_00_0_00_00_0_0_1_0;
  localparam logic [20:0] E_JMP   = 21'b1011_0_0_0_0_1_0_10_0_00_00_0_0_0_0;
  localparam logic [20:0] E_TRAP  = 21'b1100_0_0_0_0_0_0_00_0_00_00_0_0_0_1;

  typedef struct {
    string       name;
    logic [20:0] e0;
    logic [20:0] e1;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act0 !== e.e0) begin
        errors++;
        $display("FAIL %s dut0: got %b expected %b", e.name, act0, e.e0);
      end
      checks++;
      if (act1 !== e.e1) begin
        errors++;
        $display("FAIL %s dut1: got %b expected %b", e.name, act1, e.e1);
      end
    end
  end

  task automatic step2(input string nm, input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [20:0] e0, input logic [20:0] e1);
    exp_t e;
    reset     = rst;
    Opcode    = op;
    mem_ready = rdy;
    e.name = nm;
    e.e0   = e0;
    e.e1   = e1;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [20:0] e0);
    step2(nm, rst, op, rdy, e0, e0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    step("reset0", 1'b1, 6'b000000, 1'b1, E_RST);
    step("reset1", 1'b1, 6'b000000, 1'b1, E_RST);

    // R-type
    step("r_fetch",  1'b0, 6'b000000, 1'b1, E_FET_R);
    step("r_decode", 1'b0, 6'b000000, 1'b1, E_DEC);
    step("r_exec",   1'b0, 6'b000000, 1'b1, E_EXEC);
    step("r_aluwb",  1'b0, 6'b000000, 1'b1, E_AWB);

    // LW with two wait cycles in MEMRD
    step("lw_fetch",  1'b0, 6'b100011, 1'b1, E_FET_R);
    step("lw_decode", 1'b0, 6'b100011, 1'b1, E_DEC);
    step("lw_memadr", 1'b0, 6'b100011, 1'b1, E_MADR);
    step("lw_memrd0", 1'b0, 6'b100011, 1'b0, E_MRD);
    step("lw_memrd1", 1'b0, 6'b100011, 1'b0, E_MRD);
    step("lw_memrd2", 1'b0, 6'b100011, 1'b1, E_MRD);
    step("lw_memwb",  1'b0, 6'b100011, 1'b1, E_MWB);

    // SW with one wait cycle in MEMWR
    step("sw_fetch",  1'b0, 6'b101011, 1'b1, E_FET_R);
    step("sw_decode", 1'b0, 6'b101011, 1'b1, E_DEC);
    step("sw_memadr", 1'b0, 6'b101011, 1'b1, E_MADR);
    step("sw_wait",   1'b0, 6'b101011, 1'b0, E_MWR_W);
    step("sw_write",  1'b0, 6'b101011, 1'b1, E_MWR_R);

    // BEQ after one fetch wait
    step("beq_fwait",  1'b0, 6'b000100, 1'b0, E_FET_W);
    step("beq_fetch",  1'b0, 6'b000100, 1'b1, E_FET_R);
    step("beq_decode", 1'b0, 6'b000100, 1'b1, E_DEC);
    step("beq_branch", 1'b0, 6'b000100, 1'b1, E_BR);

    // ADDI
    step("addi_fetch",  1'b0, 6'b001000, 1'b1, E_FET_R);
    step("addi_decode", 1'b0, 6'b001000, 1'b1, E_DEC);
    step("addi_ex",     1'b0, 6'b001000, 1'b1, E_AIEX);
    step("addi_wb",     1'b0, 6'b001000, 1'b1, E_AIWB);

    // J: decoded by dut0, trapped by dut1
    step("j_fetch",  1'b0, 6'b000010, 1'b1, E_FET_R);
    step("j_decode", 1'b0, 6'b000010, 1'b1, E_DEC);
    step2("j_exec",  1'b0, 6'b000010, 1'b1, E_JMP, E_TRAP);

    // Illegal opcode
    step("ill_fetch",  1'b0, 6'b111111, 1'b1, E_FET_R);
    step("ill_decode", 1'b0, 6'b111111, 1'b1, E_DEC);
    step("ill_trap",   1'b0, 6'b111111, 1'b1, E_TRAP);

    // Opcode changes after DECODE are ignored in EXEC/ALUWB
    step("rchg_fetch",  1'b0, 6'b000000, 1'b1, E_FET_R);
    step("rchg_decode", 1'b0, 6'b000000, 1'b1, E_DEC);
    step("rchg_exec",   1'b0, 6'b111111, 1'b1, E_EXEC);
    step("rchg_aluwb",  1'b0, 6'b100011, 1'b1, E_AWB);

    // Reset held three cycles in MEMWR with mem_ready high
    step("swr_fetch",  1'b0, 6'b101011, 1'b1, E_FET_R);
    step("swr_decode", 1'b0, 6'b101011, 1'b1, E_DEC);
    step("swr_memadr", 1'b0, 6'b101011, 1'b1, E_MADR);
    step("swr_rst0",   1'b1, 6'b101011, 1'b1, E_RST);
    step("swr_rst1",   1'b1, 6'b101011, 1'b1, E_RST);
    step("swr_rst2",   1'b1, 6'b101011, 1'b1, E_RST);
    step("swr_after",  1'b0, 6'b101011, 1'b1, E_FET_R);
    step("swr_decode2", 1'b0, 6'b000000, 1'b1, E_DEC);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: queue depth %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
